vector_line_gen: RTL and testbench

- Upstream feeder for the mpc4922 DAC driver in the vector display.
- Accepts line segments from a display-list source through a valid/ready handshake.
- Walks each segment with integer Bresenham stepping.
- Emits every point as two single-cycle DAC strobes, X first then Y, obeying the driver's ready/strobe protocol; drives beam enable for draw versus move.

---
 rtl/vector_line_gen.sv | 184 ++++++++++++++++++
 tb/tb_vector_line_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vector_line_gen.sv
// Bresenham line walker for the vector display: accepts segments and emits each
// point as an X then Y strobe to the DAC driver, with beam enable for draws.
module vector_line_gen #(
    parameter int unsigned WIDTH = 12,
    parameter logic [15:0] DWELL = 16'd64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] seg_x,
    input  logic [WIDTH-1:0] seg_y,
    input  logic             seg_draw,
    input  logic             seg_valid,
    output logic             seg_ready,
    output logic [WIDTH-1:0] dac_value,
    output logic             dac_axis,
    output logic             dac_strobe,
    input  logic             dac_ready,
    output logic             beam_on,
    output logic             busy
);
    localparam int unsigned EW = WIDTH + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SEND_X, S_SEND_Y, S_STEP, S_DWELL
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]     px, py, tx, ty, px_nxt, py_nxt, tx_nxt, ty_nxt;
    logic                 draw, x_neg, y_neg, draw_nxt, x_neg_nxt, y_neg_nxt;
    logic signed [EW-1:0] dx, dy, err, dx_nxt, dy_nxt, err_nxt;
    logic [15:0]          dwell_cnt, dwell_cnt_nxt;
    logic [WIDTH-1:0]     dac_value_nxt;
    logic                 dac_axis_nxt, dac_strobe_nxt, beam_on_nxt, seg_ready_nxt, busy_nxt;

    logic                 accept_c, slot_c, at_target_c, step_x_c, step_y_c;
    logic signed [EW:0]   e2_c, dx_w_c, dy_w_c;
    logic [WIDTH-1:0]     abs_x_c, abs_y_c;

    // The strobe gate covers the cycle before the driver drops its ready
    assign accept_c    = (state == S_IDLE) && seg_valid && seg_ready;
    assign slot_c      = dac_ready && !dac_strobe;
    assign at_target_c = (px == tx) && (py == ty);
    assign abs_x_c     = (tx >= px) ? (tx - px) : (px - tx);
    assign abs_y_c     = (ty >= py) ? (ty - py) : (py - ty);
    assign e2_c        = {err, 1'b0};
    assign dx_w_c      = {dx[EW-1], dx};
    assign dy_w_c      = {dy[EW-1], dy};
    assign step_x_c    = (e2_c >= dy_w_c);
    assign step_y_c    = (e2_c <= dx_w_c);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept_c) state_nxt = S_SETUP;
            S_SETUP:  state_nxt = (!draw || at_target_c) ? S_SEND_X : S_STEP;
            S_STEP:   state_nxt = S_SEND_X;
            S_SEND_X: if (slot_c) state_nxt = S_SEND_Y;
            S_SEND_Y: begin
                if (slot_c) begin
                    if (!at_target_c)          state_nxt = S_STEP;
                    else if (DWELL == 16'd0)   state_nxt = S_IDLE;
                    else                       state_nxt = S_DWELL;
                end
            end
            S_DWELL:  if (dwell_cnt == DWELL - 16'd1) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Next values for datapath and registered outputs
    always_comb begin
        px_nxt         = px;
        py_nxt         = py;
        tx_nxt         = tx;
        ty_nxt         = ty;
        draw_nxt       = draw;
        x_neg_nxt      = x_neg;
        y_neg_nxt      = y_neg;
        dx_nxt         = dx;
        dy_nxt         = dy;
        err_nxt        = err;
        dwell_cnt_nxt  = dwell_cnt;
        dac_value_nxt  = dac_value;
        dac_axis_nxt   = dac_axis;
        dac_strobe_nxt = 1'b0;
        beam_on_nxt    = beam_on;
        case (state)
            S_IDLE: begin
                if (accept_c) begin
                    tx_nxt   = seg_x;
                    ty_nxt   = seg_y;
                    draw_nxt = seg_draw;
                end
            end
            S_SETUP: begin
                x_neg_nxt   = (tx < px);
                y_neg_nxt   = (ty < py);
                dx_nxt      = EW'(abs_x_c);
                dy_nxt      = -EW'(abs_y_c);
                err_nxt     = EW'(abs_x_c) - EW'(abs_y_c);
                beam_on_nxt = draw;
                if (!draw) begin
                    px_nxt = tx;
                    py_nxt = ty;
                end
            end
            S_STEP: begin
                err_nxt = err + (step_x_c ? dy : EW'(0)) + (step_y_c ? dx : EW'(0));
                if (step_x_c) px_nxt = x_neg ? (px - WIDTH'(1)) : (px + WIDTH'(1));
                if (step_y_c) py_nxt = y_neg ? (py - WIDTH'(1)) : (py + WIDTH'(1));
                beam_on_nxt = draw;
            end
            S_SEND_X: begin
                if (slot_c) begin
                    dac_strobe_nxt = 1'b1;
                    dac_axis_nxt   = 1'b1;
                    dac_value_nxt  = px;
                end
            end
            S_SEND_Y: begin
                if (slot_c) begin
                    dac_strobe_nxt = 1'b1;
                    dac_axis_nxt   = 1'b0;
                    dac_value_nxt  = py;
                    dwell_cnt_nxt  = '0;
                    if (at_target_c && DWELL == 16'd0) beam_on_nxt = 1'b0;
                end
            end
            S_DWELL: begin
                if (dwell_cnt == DWELL - 16'd1) beam_on_nxt = 1'b0;
                else                            dwell_cnt_nxt = dwell_cnt + 16'd1;
            end
            default: ;
        endcase
        seg_ready_nxt = (state_nxt == S_IDLE);
        busy_nxt      = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            px         <= '0;
            py         <= '0;
            tx         <= '0;
            ty         <= '0;
            draw       <= 1'b0;
            x_neg      <= 1'b0;
            y_neg      <= 1'b0;
            dx         <= '0;
            dy         <= '0;
            err        <= '0;
            dwell_cnt  <= '0;
            dac_value  <= '0;
            dac_axis   <= 1'b0;
            dac_strobe <= 1'b0;
            beam_on    <= 1'b0;
            seg_ready  <= 1'b1;
            busy       <= 1'b0;
        end else begin
            px         <= px_nxt;
            py         <= py_nxt;
            tx         <= tx_nxt;
            ty         <= ty_nxt;
            draw       <= draw_nxt;
            x_neg      <= x_neg_nxt;
            y_neg      <= y_neg_nxt;
            dx         <= dx_nxt;
            dy         <= dy_nxt;
            err        <= err_nxt;
            dwell_cnt  <= dwell_cnt_nxt;
            dac_value  <= dac_value_nxt;
            dac_axis   <= dac_axis_nxt;
            dac_strobe <= dac_strobe_nxt;
            beam_on    <= beam_on_nxt;
            seg_ready  <= seg_ready_nxt;
            busy       <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_vector_line_gen.sv
// Bench for vector_line_gen: DAC driver model plus a point-list reference model
// derived from integer line rules, driving directed and random segments.
module tb_vector_line_gen;
    localparam int W     = 12;
    localparam int DW    = 64;
    localparam int LIMIT = 20000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  seg_x = '0, seg_y = '0;
    logic          seg_draw = 1'b0, seg_valid = 1'b0;
    logic          seg_ready, dac_axis, dac_strobe, beam_on, busy;
    logic [W-1:0]  dac_value;
    logic          dac_ready = 1'b1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_strobe_cyc = 0;
    int cur_x = 0, cur_y = 0;
    int rx_q[$];
    int exp_q[$];
    bit hold = 1'b0;
    bit exp_beam = 1'b0;
    bit pend = 1'b0, prev_strobe = 1'b0;
    int drv_busy = 0;

    vector_line_gen #(.WIDTH(W), .DWELL(16'(DW))) dut (
        .clk(clk), .reset(reset), .seg_x(seg_x), .seg_y(seg_y), .seg_draw(seg_draw),
        .seg_valid(seg_valid), .seg_ready(seg_ready), .dac_value(dac_value),
        .dac_axis(dac_axis), .dac_strobe(dac_strobe), .dac_ready(dac_ready),
        .beam_on(beam_on), .busy(busy)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int entry(input int axis, input int v);
        return (axis << 16) | v;
    endfunction

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : ((v > 4095) ? 4095 : v);
    endfunction

    // DAC driver: ready falls one cycle after it samples a strobe, busy 1..4 cycles
    always @(negedge clk) begin
        if (!reset) begin
            pend = 1'b0; drv_busy = 0; prev_strobe = 1'b0; dac_ready = 1'b1;
        end else begin
            if (dac_strobe) begin
                check("ready_at_strobe", 32'(dac_ready), 32'd1);
                check("strobe_gap", 32'(prev_strobe), 32'd0);
                check("beam_at_strobe", 32'(beam_on), 32'(exp_beam));
                rx_q.push_back(entry(int'(dac_axis), int'(dac_value)));
                last_strobe_cyc = cyc;
                pend = 1'b1;
            end else if (pend) begin
                pend = 1'b0;
                drv_busy = int'($urandom_range(1, 4));
            end else if (drv_busy > 0) begin
                drv_busy--;
            end
            prev_strobe = dac_strobe;
            dac_ready = (drv_busy == 0) && !hold;
        end
    end

    // Expected point list: target for moves/zero length, else every step point
    task automatic model_seg(input int tx, input int ty, input bit drw);
        int x, y, dx, dy, sx, sy, err, e2;
        exp_q.delete();
        x = cur_x; y = cur_y;
        if (!drw || (tx == x && ty == y)) begin
            exp_q.push_back(entry(1, tx));
            exp_q.push_back(entry(0, ty));
        end else begin
            dx  = (tx > x) ? tx - x : x - tx;
            dy  = -((ty > y) ? ty - y : y - ty);
            sx  = (tx >= x) ? 1 : -1;
            sy  = (ty >= y) ? 1 : -1;
            err = dx + dy;
            while (!(x == tx && y == ty)) begin
                e2 = 2 * err;
                if (e2 >= dy) begin err += dy; x += sx; end
                if (e2 <= dx) begin err += dx; y += sy; end
                exp_q.push_back(entry(1, x));
                exp_q.push_back(entry(0, y));
            end
        end
        cur_x = tx; cur_y = ty;
    endtask

    task automatic start_seg(input int tx, input int ty, input bit drw);
        check("ready_before_seg", 32'(seg_ready), 32'd1);
        exp_beam = drw;
        @(negedge clk);
        seg_x = W'(tx); seg_y = W'(ty); seg_draw = drw; seg_valid = 1'b1;
        @(posedge clk); #1;
        seg_valid = 1'b0;
        check("ready_drop", 32'(seg_ready), 32'd0);
        check("busy_rise", 32'(busy), 32'd1);
    endtask

    task automatic run_seg(input int tx, input int ty, input bit drw, input int bp_at);
        int base, bp_left, n;
        bit done, prev_beam, bp_started;
        model_seg(tx, ty, drw);
        base = rx_q.size();
        start_seg(tx, ty, drw);
        done = 1'b0; prev_beam = beam_on; bp_left = 0; bp_started = 1'b0;
        for (int c = 0; c < LIMIT; c++) begin
            if (!busy) begin done = 1'b1; break; end
            prev_beam = beam_on;
            if (bp_at > 0 && !bp_started && rx_q.size() - base >= bp_at) begin
                hold = 1'b1; bp_started = 1'b1; bp_left = 50;
            end else if (bp_left > 0) begin
                check("bp_no_strobe", 32'(dac_strobe), 32'd0);
                check("bp_value_stable", 32'(dac_value), 32'(exp_q[bp_at-1] & 32'hFFF));
                bp_left--;
                if (bp_left == 0) hold = 1'b0;
            end
            @(posedge clk); #1;
        end
        hold = 1'b0;
        check("seg_timeout", 32'(done), 32'd1);
        check("dwell_cycles", 32'(cyc - last_strobe_cyc), 32'(DW));
        check("beam_in_dwell", 32'(prev_beam), 32'(drw));
        check("beam_off_idle", 32'(beam_on), 32'd0);
        check("ready_idle", 32'(seg_ready), 32'd1);
        n = rx_q.size() - base;
        check("strobe_count", 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n; i++)
            check($sformatf("point%0d", i), 32'(rx_q[base+i]), 32'(exp_q[i]));
    endtask

    initial begin
        int base, tx, ty;
        bit reached;
        repeat (3) @(posedge clk);
        #1;
        check("rst_strobe", 32'(dac_strobe), 32'd0);
        check("rst_value", 32'(dac_value), 32'd0);
        check("rst_axis", 32'(dac_axis), 32'd0);
        check("rst_beam", 32'(beam_on), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("rel_ready", 32'(seg_ready), 32'd1);

        run_seg(4, 0, 1'b1, 0);          // horizontal
        run_seg(0, 3, 1'b1, 0);          // diagonal back to the left
        run_seg(100, 200, 1'b0, 0);      // move
        run_seg(100, 200, 1'b1, 0);      // zero length
        run_seg(500, 500, 1'b0, 0);
        run_seg(560, 530, 1'b1, 20);     // backpressure mid-line
        for (int k = 0; k < 10; k++) begin
            tx = clamp(cur_x + int'($urandom_range(0, 80)) - 40);
            ty = clamp(cur_y + int'($urandom_range(0, 80)) - 40);
            run_seg(tx, ty, $urandom_range(0, 3) != 0, 0);
        end
        run_seg(4095, 4095, 1'b0, 0);
        run_seg(4040, 4080, 1'b1, 0);
        run_seg(4095, 4060, 1'b1, 0);

        // Asynchronous reset while waiting to send Y of a long line
        base = rx_q.size();
        start_seg(3900, 3980, 1'b1);
        reached = 1'b0;
        for (int c = 0; c < LIMIT; c++) begin
            if (rx_q.size() - base >= 11) begin reached = 1'b1; break; end
            @(posedge clk); #1;
        end
        check("reach_send_y", 32'(reached), 32'd1);
        hold = 1'b1;
        repeat (3) @(posedge clk);
        #4;
        reset = 1'b0;
        #1;
        check("async_strobe", 32'(dac_strobe), 32'd0);
        check("async_value", 32'(dac_value), 32'd0);
        check("async_axis", 32'(dac_axis), 32'd0);
        check("async_beam", 32'(beam_on), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        hold = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        cur_x = 0; cur_y = 0;
        run_seg(5, 7, 1'b1, 0);
        run_seg(2, 1, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
